aes_round_seq: RTL



---
 rtl/aes_pkg.sv | 15 +
 rtl/aes_round_seq_if.sv | 26 ++
 rtl/aes_rcon_gen.sv | 34 +++
 rtl/aes_round_seq.sv | 98 +++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and the GF(2^8) doubling helper for the AES-128 round sequencer.
// Optional build macro used by the sequencer: AES_SEQ_ABORT_EN.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    localparam int         AES_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_seq_if.sv
// Bus bundle between the AES round sequencer, its host and the external
// key-expansion / round-datapath stages.
interface aes_round_seq_if;
    logic         load;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic [127:0] rk_cur;
    logic [7:0]   rcon;
    logic [127:0] rk_next;
    logic [127:0] st_cur;
    logic         final_rnd;
    logic [127:0] st_next;
    logic         busy;
    logic         done;
    logic [127:0] cyphertext;

    modport slave (
        input  load, key, plaintext, rk_next, st_next,
        output rk_cur, rcon, st_cur, final_rnd, busy, done, cyphertext
    );

    modport master (
        output load, key, plaintext, rk_next, st_next,
        input  rk_cur, rcon, st_cur, final_rnd, busy, done, cyphertext
    );
endinterface

// File: rtl/aes_rcon_gen.sv
// Round counter and round-constant register; the counter saturates on the
// last round so it never wraps past NUM_ROUNDS.
module aes_rcon_gen
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_ROUNDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       step,
    output logic [7:0] rcon,
    output logic [3:0] round,
    output logic       last
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    assign last = (round == LAST_ROUND);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcon  <= RCON_INIT;
            round <= 4'd1;
        end else if (start) begin
            rcon  <= RCON_INIT;
            round <= 4'd1;
        end else if (step && !last) begin
            rcon  <= xtime(rcon);
            round <= round + 4'd1;
        end
    end

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES-128 round sequencer: one round per clock against external
// combinational key-expansion and round stages. Macro AES_SEQ_ABORT_EN lets load restart a running block.
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_ROUNDS
) (
    input  logic            clk,
    input  logic            reset,
    aes_round_seq_if.slave  bus
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    seq_state_t state, state_nxt;
    logic       start;
    logic       step;
    logic       capture;
    logic       last;
    logic       abort_req;
    logic [3:0] round;

`ifdef AES_SEQ_ABORT_EN
    assign abort_req = bus.load;
`else
    assign abort_req = 1'b0;
`endif

    aes_rcon_gen #(.NUM_ROUNDS(NUM_ROUNDS)) u_rcon (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .step  (step),
        .rcon  (bus.rcon),
        .round (round),
        .last  (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        step      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.load) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort_req) begin
                    start = 1'b1;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        capture   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Round key and state advance together so rk_next always pairs with st_cur
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rk_cur     <= '0;
            bus.st_cur     <= '0;
            bus.cyphertext <= '0;
        end else begin
            if (start) begin
                bus.st_cur <= bus.plaintext ^ bus.key;
                bus.rk_cur <= bus.key;
            end else if (step) begin
                bus.st_cur <= bus.st_next;
                bus.rk_cur <= bus.rk_next;
            end
            if (capture) begin
                bus.cyphertext <= bus.st_next;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.final_rnd = (state == RUN) && (round == LAST_ROUND);

endmodule
